// File: rtl/session_pkg.sv
// session_pkg: shared FSM state encoding and counter-width helper for the session controller
package session_pkg;
  typedef enum logic [3:0] {
    ENTRY, CHECK, LOCKOUT, GRANTED, CONFIG, READY, PLAY, PAUSE, MENU, SCORE, SCORE_ACK
  } state_t;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cycle_window_timer.sv
// cycle_window_timer: start loads a CYCLES-long window; expired is high from the last in-window cycle onward (ports: clk, reset, start, expired)
module cycle_window_timer
  import session_pkg::*;
#(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic expired
);
  localparam int W = cnt_w(CYCLES);
  logic [W-1:0] cnt;
  logic         running;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= W'(CYCLES - 1);
      running <= 1'b1;
    end else if (running && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end
  assign expired = running && cnt == '0;
endmodule

// File: rtl/session_controller.sv
// session_controller: PIN entry with lockout, then config/ready/play/pause/menu/score sequencing (ports: clk, reset, load_password, pin_digit, pushButtonLoad_RNG, pushButtonLoad2, timeout -> load_sig_RNG, load_sig_2, reconfig, enable, passredled, passgreenled, locked, fail_count)
module session_controller
  import session_pkg::*;
#(
  parameter int                            DIGIT_W        = 4,
  parameter int                            PIN_LEN        = 4,
  parameter logic [PIN_LEN*DIGIT_W-1:0]    PIN_VALUE      = 16'h4014,
  parameter int                            MAX_FAILS      = 3,
  parameter int                            LOCKOUT_CYCLES = 1000,
  parameter int                            HOLD_CYCLES    = 50_000_000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load_password,
  input  logic [DIGIT_W-1:0]                 pin_digit,
  input  logic                               pushButtonLoad_RNG,
  input  logic                               pushButtonLoad2,
  input  logic                               timeout,
  output logic                               load_sig_RNG,
  output logic                               load_sig_2,
  output logic                               reconfig,
  output logic                               enable,
  output logic                               passredled,
  output logic                               passgreenled,
  output logic                               locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);
  localparam int IDX_W = cnt_w(PIN_LEN);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               mism, mism_n, armed, armed_n;
  logic [FC_W-1:0]    fail_n, fail_inc;
  logic               reconfig_n, win_start, win_exp, lock_start, lock_exp;
  logic [DIGIT_W-1:0] digits [PIN_LEN];
  for (genvar i = 0; i < PIN_LEN; i++) begin : g_digit
    assign digits[i] = PIN_VALUE[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W];
  end
  cycle_window_timer #(.CYCLES(HOLD_CYCLES)) u_win (
    .clk(clk), .reset(reset), .start(win_start), .expired(win_exp)
  );
  cycle_window_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lock (
    .clk(clk), .reset(reset), .start(lock_start), .expired(lock_exp)
  );
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    mism_n     = mism;
    armed_n    = armed;
    fail_n     = fail_count;
    fail_inc   = fail_count + 1'b1;
    reconfig_n = 1'b0;
    win_start  = 1'b0;
    lock_start = 1'b0;
    case (state)
      ENTRY: if (load_password) begin
        mism_n  = mism | (pin_digit != digits[idx]);
        idx_n   = idx + 1'b1;
        state_n = (idx == IDX_W'(PIN_LEN - 1)) ? CHECK : ENTRY;
      end
      CHECK: begin
        idx_n      = '0;
        mism_n     = 1'b0;
        fail_n     = mism ? fail_inc : '0;
        lock_start = mism && fail_inc == FC_W'(MAX_FAILS);
        state_n    = !mism ? GRANTED : lock_start ? LOCKOUT : ENTRY;
      end
      LOCKOUT: if (lock_exp) begin
        fail_n  = '0;
        state_n = ENTRY;
      end
      GRANTED: state_n = CONFIG;
      CONFIG: if (load_password) begin
        reconfig_n = 1'b1;
        state_n    = READY;
      end
      READY: state_n = load_password ? PLAY : READY;
      PLAY: if (timeout) state_n = SCORE;
        else if (load_password) begin
          state_n   = PAUSE;
          win_start = 1'b1;
          armed_n   = 1'b0;
        end
      PAUSE: if (load_password) begin
        state_n   = armed ? PLAY : MENU;
        win_start = !armed;
      end else if (win_exp) armed_n = 1'b1;
      MENU: if (load_password) state_n = ENTRY;
        else if (win_exp) begin
          reconfig_n = 1'b1;
          state_n    = CONFIG;
        end
      SCORE: state_n = load_password ? SCORE_ACK : SCORE;
      SCORE_ACK: state_n = load_password ? CONFIG : SCORE_ACK;
      default: begin
        state_n = ENTRY;
        idx_n   = '0;
        mism_n  = 1'b0;
        armed_n = 1'b0;
        fail_n  = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ENTRY;
      idx          <= '0;
      mism         <= 1'b0;
      armed        <= 1'b0;
      fail_count   <= '0;
      load_sig_RNG <= 1'b1;
      load_sig_2   <= 1'b0;
      reconfig     <= 1'b0;
      enable       <= 1'b0;
      passredled   <= 1'b1;
      passgreenled <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      mism         <= mism_n;
      armed        <= armed_n;
      fail_count   <= fail_n;
      load_sig_RNG <= (state_n == PLAY) ? pushButtonLoad_RNG : 1'b1;
      load_sig_2   <= (state_n == PLAY) && pushButtonLoad2;
      reconfig     <= reconfig_n;
      enable       <= state_n == PLAY;
      passredled   <= state_n inside {ENTRY, CHECK, LOCKOUT};
      passgreenled <= !(state_n inside {ENTRY, CHECK, LOCKOUT});
      locked       <= state_n == LOCKOUT;
    end
  end
endmodule

// File: doc/session_controller.md
# session_controller

Parametrised player-session controller for the mental-math game. It authenticates a multi-digit PIN entered one digit per `load_password` press and locks out after repeated failures. It then sequences timer reconfiguration, game ready, play, pause/resume/logout and score hold. It sits between the button shapers and the RNG/operand load registers and game timer, and drives the pass/fail LEDs.

## Interface
Parameters:
- `DIGIT_W`, 4: width of one PIN digit.
- `PIN_LEN`, 4: number of digits per PIN entry (≥1).
- `PIN_VALUE`, 16'h4014: packed expected PIN, `PIN_LEN*DIGIT_W` bits; digit 0 is the most significant nibble and is entered first.
- `MAX_FAILS`, 3: consecutive wrong entries that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 1000: lockout duration in clk cycles.
- `HOLD_CYCLES`, 50_000_000: pause decision window in clk cycles.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `load_password` in 1: one-cycle shaped press (digit enter / advance / pause).
- `pin_digit` in DIGIT_W: digit sampled on `load_password`.
- `pushButtonLoad_RNG` in 1: shaped press, forwarded during play.
- `pushButtonLoad2` in 1: shaped press, forwarded during play.
- `timeout` in 1: game timer expiry, level.
- `load_sig_RNG` out 1: RNG load/hold control.
- `load_sig_2` out 1: operand-2 load.
- `reconfig` out 1: one-cycle timer reconfigure pulse.
- `enable` out 1: game timer run.
- `passredled` out 1: red LED.
- `passgreenled` out 1: green LED.
- `locked` out 1: lockout active.
- `fail_count` out $clog2(MAX_FAILS+1): consecutive failures.

## Operation
- Reset values: `load_sig_RNG`=1, `load_sig_2`=0, `reconfig`=0, `enable`=0, `passredled`=1, `passgreenled`=0, `locked`=0, `fail_count`=0. State is ENTRY, digit index 0, mismatch flag clear, window timer idle.
- **ENTRY**
  - On each press, compare `pin_digit` with digit[idx], OR any mismatch into the flag, and increment idx.
  - The press at idx=PIN_LEN-1 moves to CHECK.
  - Red=1, green=0.
- **CHECK** (one cycle)
  - Flag clear: `fail_count`←0, go to GRANTED.
  - Flag set: `fail_count`+1. Go to LOCKOUT if the new count equals MAX_FAILS, else back to ENTRY.
  - Leaving CHECK always clears idx and the flag.
- **LOCKOUT**
  - `locked`=1; presses are ignored.
  - After LOCKOUT_CYCLES cycles: `fail_count`←0, `locked`←0, go to ENTRY.
- **GRANTED** (one cycle): green←1, red←0, go to CONFIG.
- **CONFIG**: on a press, pulse `reconfig` for one cycle and go to READY.
- **READY**: on a press, go to PLAY.
- **PLAY**
  - `enable`=1, `load_sig_RNG`=`pushButtonLoad_RNG`, `load_sig_2`=`pushButtonLoad2`; both are registered, one cycle late.
  - `timeout`=1 goes to SCORE; this has priority over a simultaneous press.
  - A press goes to PAUSE and starts the window timer.
- **PAUSE**
  - `enable`=0, `load_sig_RNG`=1, `load_sig_2`=0.
  - Press while the window is running: go to MENU and restart the window.
  - Window expired: resume is armed. A later press returns to PLAY.
- **MENU**
  - Press while the window is running: logout. Go to ENTRY with LEDs red, `fail_count` unchanged (0).
  - Window expires first: pulse `reconfig` and go to CONFIG.
- **SCORE**
  - `enable`=0, `load_sig_RNG`=1, `load_sig_2`=0.
  - A press goes to SCORE_ACK; the next press goes to CONFIG.
- Any unused state encoding goes to ENTRY with reset output values.
- `reset` mid-operation has priority over everything and restores reset values on the next edge, including from LOCKOUT.

## Timing
- All outputs are registered. A press at edge N produces its state change and output change at edge N+1.
- CHECK adds one cycle: green rises 2 cycles after the last-digit press.
- Window: expiry is declared exactly HOLD_CYCLES cycles after entering PAUSE or MENU. A press on the expiry cycle counts as inside the window.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles from entry to ENTRY.
- `reconfig` is high for exactly one cycle per event.

## Structure
- `session_pkg`: state enum (ENTRY, CHECK, LOCKOUT, GRANTED, CONFIG, READY, PLAY, PAUSE, MENU, SCORE, SCORE_ACK) and a helper function for the counter width.
- Sub-module `cycle_window_timer` (params `CYCLES`; ports `clk`, `reset`, `start`, `expired`) is instantiated twice: once for the pause window and once for the lockout.

## Test plan
- Defaults, digits 4,0,1,4 → green=1, red=0 two cycles after the 4th press; `fail_count`=0.
- Digits 4,0,1,5, three times (MAX_FAILS=3, LOCKOUT_CYCLES=20) → `fail_count` goes 1,2 then `locked`=1 for 20 cycles. Presses during lockout are ignored; afterwards `fail_count`=0 and the state is ENTRY.
- In PLAY, `pushButtonLoad2` pulse → `load_sig_2`=1 one cycle later. Assert `timeout` together with a press → SCORE, `enable`=0.
- Pause, wait longer than HOLD_CYCLES (set to 8), press → PLAY with `enable`=1. Pause, press within 8 cycles, wait 8 → one-cycle `reconfig`, CONFIG.
- Pause, press, press within the window → ENTRY with red=1.
- Assert `reset` during PLAY and during LOCKOUT → all outputs at reset values on the next edge.
